cordic_cos_pipeline: RTL and testbench
======================================

Name: cordic_cos_pipeline

Overview:
- Pipelined rotation-mode CORDIC core that computes cosine and sine of a fixed-point angle, accepting one new angle per clock.
- Sits between the float-to-fixed converter and the fixed-to-float converter in the cosine datapath.
- Also carries an IEEE-754 halving side path, delay-matched to the CORDIC result.

Parameters:
- WORD_LENGTH, 21: signed fixed-point width, format Q2.19 (sign bit, 1 integer bit, 19 fraction bits).
- N_ITERATIONS, 17: number of CORDIC micro-rotations; the register placement below is defined for this value only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- z_i  in  WORD_LENGTH  signed angle in radians, Q2.19
- valid_i  in  1  z_i/fp_i qualifier
- fp_i  in  32  IEEE-754 single value to be halved
- cos_o  out  WORD_LENGTH  signed cos(z_i), Q2.19
- sin_o  out  WORD_LENGTH  signed sin(z_i), Q2.19
- half_o  out  32  fp_i/2, IEEE-754, aligned with cos_o
- valid_o  out  1  valid_i delayed by the pipeline latency

Behaviour:
- Initial vector: x0 = 318375 (0.6072540, i.e. 1/K), y0 = 0, z = z_i.
- Iteration i = 0..16, with d = +1 if z >= 0, else -1:
  - x' = x - d*(y >>> i)
  - y' = y + d*(x >>> i)
  - z' = z - d*alpha[i]
- Shifts are arithmetic. All sums are WORD_LENGTH-bit two's-complement; they wrap and do not saturate.
- alpha[i] is a constant table, integer = value*2^19:
  - 411775, 243085, 128439, 65198, 32725, 16379, 8191
  - then 4096, 2048, 1024, 512, 256, 128, 64, 32, 16, 8 for i = 7..16.
- Pipeline registers (x, y, z, plus valid and the 32-bit half value) sit after iterations 2, 5, 8, 11 and 14.
- Iterations 15–16 are combinational after the last register. cos_o = x17, sin_o = y17.
- Latency is 5 clock edges: data presented before edge n appears on the outputs after edge n+4. Throughput is 1 per cycle.
- Input range: |z_i| <= ~1.74 rad (pi/2 with margin). Behaviour outside this range is undefined but must not hang.
- Accuracy: |error| <= 16 LSB versus the true cos/sin over |z| <= pi/2.
- Reset: all pipeline registers clear to 0 asynchronously, so valid_o = 0 during and after reset.
  - While rst is high, cos_o/sin_o equal the tail iterations applied to zero state (not meaningful; valid_o = 0).
  - A reset asserted mid-stream discards in-flight data; no stale valid_o follows deassertion.
- Halving (combinational, then delayed). Let s = sign, e = exponent, m = mantissa of fp_i; sign is always preserved.
  - e = 255 (inf/NaN): pass through unchanged.
  - 2 <= e <= 254: result e-1, same m.
  - e = 1: result e = 0, m = {1, m[22:1]} (becomes denormal).
  - e = 0 (zero/denormal): m >> 1, truncated.

Decomposition:
- Shared package holds:
  - WORD_LENGTH and the Q2.19 fraction-bit count
  - the x0 constant
  - the 17-entry alpha table
  - pipeline register stage indices
- One natural sub-module: cordic_stage, a combinational single micro-rotation taking x/y/z, alpha and a shift amount, instantiated 17 times via generate.
- The halving logic and pipeline registers are inline.

Test Plan:
- z_i = 0, valid_i = 1 -> after 5 edges: cos_o = 524288±16 (1.0), sin_o = 0±16, valid_o = 1.
- z_i = 411775 (pi/4) -> cos_o ≈ 370727±16, sin_o ≈ 370727±16. z_i = -411775 -> same cos_o, sin_o ≈ -370727.
- z_i = 823550 (pi/2) -> cos_o = 0±16, sin_o = 524288±16.
- Back-to-back stream of 20 random angles in ±1.5 rad, one per cycle -> outputs match the reference model in order, 5 cycles late, no bubbles.
- fp_i = 0x40000000 (2.0) -> half_o = 0x3F800000.
  - 0xC0800000 -> 0xC0000000.
  - 0x7F800000 -> unchanged.
  - 0x00800000 -> 0x00400000.
  - 0x00000002 -> 0x00000001.
- Assert rst for 1 cycle while 3 valid samples are in flight -> valid_o = 0 immediately and stays 0 until new valid_i data has travelled 5 edges.

Source files
------------

// File: rtl/cordic_cos_pipeline_pkg.sv
// Shared constants for the rotation-mode CORDIC cosine pipeline:
// Q2.19 word format, initial x vector, arctangent table and register placement.
package cordic_cos_pipeline_pkg;

  localparam int unsigned WORD_LENGTH  = 21;
  localparam int unsigned FRAC_BITS    = 19;
  localparam int unsigned N_ITERATIONS = 17;
  localparam int unsigned N_REGS       = 5;

  // 1/K pre-scales x so that the outputs need no gain correction
  localparam logic signed [WORD_LENGTH-1:0] X0 = 21'sd318375;

  localparam logic signed [WORD_LENGTH-1:0] ALPHA [0:N_ITERATIONS-1] = '{
    21'sd411775, 21'sd243085, 21'sd128439, 21'sd65198, 21'sd32725, 21'sd16379,
    21'sd8191,   21'sd4096,   21'sd2048,   21'sd1024,  21'sd512,   21'sd256,
    21'sd128,    21'sd64,     21'sd32,     21'sd16,    21'sd8
  };

  localparam int unsigned REG_STAGES [0:N_REGS-1] = '{2, 5, 8, 11, 14};

  function automatic bit is_reg_stage(input int unsigned idx);
    bit hit;
    hit = 1'b0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      if (REG_STAGES[k] == idx) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cordic_cos_pipeline_stage.sv
// One combinational CORDIC micro-rotation; direction follows the sign of z.
module cordic_stage #(
  parameter int unsigned WIDTH = 21
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic signed [WIDTH-1:0] alpha,
  input  logic        [4:0]       shift,
  output logic signed [WIDTH-1:0] x_next,
  output logic signed [WIDTH-1:0] y_next,
  output logic signed [WIDTH-1:0] z_next
);

  logic signed [WIDTH-1:0] x_shr;
  logic signed [WIDTH-1:0] y_shr;

  always_comb begin
    x_shr = x >>> shift;
    y_shr = y >>> shift;
    if (!z[WIDTH-1]) begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - alpha;
    end else begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + alpha;
    end
  end

endmodule

// File: rtl/cordic_cos_pipeline.sv
// Pipelined CORDIC cos/sin core with a delay-matched IEEE-754 halving side path.
module cordic_cos_pipeline
  import cordic_cos_pipeline_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = cordic_cos_pipeline_pkg::WORD_LENGTH,
  parameter int unsigned N_ITERATIONS = cordic_cos_pipeline_pkg::N_ITERATIONS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [WORD_LENGTH-1:0] z_i,
  input  logic                          valid_i,
  input  logic        [31:0]            fp_i,
  output logic signed [WORD_LENGTH-1:0] cos_o,
  output logic signed [WORD_LENGTH-1:0] sin_o,
  output logic        [31:0]            half_o,
  output logic                          valid_o
);

  logic signed [WORD_LENGTH-1:0] x_in  [0:N_ITERATIONS];
  logic signed [WORD_LENGTH-1:0] y_in  [0:N_ITERATIONS];
  logic signed [WORD_LENGTH-1:0] z_in  [0:N_ITERATIONS];
  logic signed [WORD_LENGTH-1:0] x_out [0:N_ITERATIONS-1];
  logic signed [WORD_LENGTH-1:0] y_out [0:N_ITERATIONS-1];
  logic signed [WORD_LENGTH-1:0] z_out [0:N_ITERATIONS-1];

  assign x_in[0] = X0;
  assign y_in[0] = '0;
  assign z_in[0] = z_i;

  // Iteration i feeds i+1 either directly or through a register bank
  for (genvar i = 0; i < N_ITERATIONS; i++) begin : g_iter
    cordic_stage #(.WIDTH(WORD_LENGTH)) u_stage (
      .x      (x_in[i]),
      .y      (y_in[i]),
      .z      (z_in[i]),
      .alpha  (ALPHA[i]),
      .shift  (5'(i)),
      .x_next (x_out[i]),
      .y_next (y_out[i]),
      .z_next (z_out[i])
    );

    if (is_reg_stage(i)) begin : g_reg
      logic signed [WORD_LENGTH-1:0] x_q, y_q, z_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
          z_q <= '0;
        end else begin
          x_q <= x_out[i];
          y_q <= y_out[i];
          z_q <= z_out[i];
        end
      end
      assign x_in[i+1] = x_q;
      assign y_in[i+1] = y_q;
      assign z_in[i+1] = z_q;
    end else begin : g_wire
      assign x_in[i+1] = x_out[i];
      assign y_in[i+1] = y_out[i];
      assign z_in[i+1] = z_out[i];
    end
  end

  assign cos_o = x_in[N_ITERATIONS];
  assign sin_o = y_in[N_ITERATIONS];

  logic [31:0] half_val;
  logic [7:0]  fp_exp;

  always_comb begin
    fp_exp   = fp_i[30:23];
    half_val = fp_i;
    if (fp_exp == 8'd255) begin
      half_val = fp_i;
    end else if (fp_exp >= 8'd2) begin
      half_val[30:23] = fp_exp - 8'd1;
    end else if (fp_exp == 8'd1) begin
      half_val = {fp_i[31], 8'd0, 1'b1, fp_i[22:1]};
    end else begin
      half_val = {fp_i[31], 8'd0, 1'b0, fp_i[22:1]};
    end
  end

  logic [31:0] half_pipe  [0:N_REGS-1];
  logic        valid_pipe [0:N_REGS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_REGS; k++) begin
        half_pipe[k]  <= '0;
        valid_pipe[k] <= 1'b0;
      end
    end else begin
      half_pipe[0]  <= half_val;
      valid_pipe[0] <= valid_i;
      for (int unsigned k = 1; k < N_REGS; k++) begin
        half_pipe[k]  <= half_pipe[k-1];
        valid_pipe[k] <= valid_pipe[k-1];
      end
    end
  end

  assign half_o  = half_pipe[N_REGS-1];
  assign valid_o = valid_pipe[N_REGS-1];

endmodule

// File: tb/tb_cordic_cos_pipeline.sv
// Self-checking bench: directed and random angles/floats against an arithmetic reference.
module tb_cordic_cos_pipeline;

  localparam int WL = 21;
  localparam int LATENCY = 5;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [WL-1:0] z_i = '0;
  logic                 valid_i = 1'b0;
  logic [31:0]          fp_i = '0;
  logic signed [WL-1:0] cos_o;
  logic signed [WL-1:0] sin_o;
  logic [31:0]          half_o;
  logic                 valid_o;

  cordic_cos_pipeline #(.WORD_LENGTH(21), .N_ITERATIONS(17)) dut (
    .clk     (clk),
    .rst     (rst),
    .z_i     (z_i),
    .valid_i (valid_i),
    .fp_i    (fp_i),
    .cos_o   (cos_o),
    .sin_o   (sin_o),
    .half_o  (half_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          cos_exact;
    int          sin_exact;
    int          cos_true;
    int          sin_true;
    logic [31:0] half;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input int got, input int want, input int tol = 0);
    int diff;
    n_vec++;
    diff = got - want;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h) tol %0d at cycle %0d",
               tag, got, got, want, want, tol, cycle);
    end
  endtask

  int alpha_tab [17] = '{411775, 243085, 128439, 65198, 32725, 16379, 8191,
                         4096, 2048, 1024, 512, 256, 128, 64, 32, 16, 8};

  function automatic int wrap21(input int v);
    logic signed [20:0] t;
    t = v[20:0];
    return int'(t);
  endfunction

  // Rotation-mode CORDIC on plain integers with 21-bit wrap-around
  function automatic void ref_cordic(input int z0, output int c, output int s);
    int x, y, z, xn, yn;
    x = 318375; y = 0; z = z0;
    for (int i = 0; i < 17; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - alpha_tab[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + alpha_tab[i];
      end
      x = wrap21(xn); y = wrap21(yn); z = wrap21(z);
    end
    c = x; s = y;
  endfunction

  // Halving by value: e>=2 just drops the exponent, otherwise shift the full significand
  function automatic logic [31:0] ref_half(input logic [31:0] f);
    int          e;
    logic [23:0] sig;
    e = int'(f[30:23]);
    if (e == 255) return f;
    if (e >= 2) return {f[31], 8'(e - 1), f[22:0]};
    sig = (e == 1) ? {1'b1, f[22:0]} : {1'b0, f[22:0]};
    sig = sig >> 1;
    return {f[31], 8'd0, sig[22:0]};
  endfunction

  task automatic send(input int z, input logic [31:0] f);
    exp_t e;
    real  ang;
    @(posedge clk); #1;
    z_i = WL'(z);
    fp_i = f;
    valid_i = 1'b1;
    ang = real'(z) / 524288.0;
    e.due = cycle + LATENCY;
    ref_cordic(z, e.cos_exact, e.sin_exact);
    e.cos_true = int'($rtoi($cos(ang) * 524288.0 + ((ang > 10.0) ? 0.0 : 0.5)));
    e.sin_true = $rtoi($floor($sin(ang) * 524288.0 + 0.5));
    e.cos_true = $rtoi($floor($cos(ang) * 524288.0 + 0.5));
    e.half = ref_half(f);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      z_i = WL'($urandom);
      fp_i = $urandom;
    end
  endtask

  function automatic logic [31:0] rand_fp();
    int          pick;
    logic [7:0]  e;
    pick = int'($urandom_range(0, 5));
    case (pick)
      0: e = 8'd0;
      1: e = 8'd1;
      2: e = 8'd2;
      3: e = 8'd254;
      4: e = 8'd255;
      default: e = 8'($urandom_range(3, 253));
    endcase
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Every falling edge: valid_o must be high exactly when a result is due
  always @(negedge clk) begin
    exp_t e;
    logic want_v;
    want_v = (exp_q.size() > 0) && (exp_q[0].due == cycle);
    check("valid", int'(valid_o), int'(want_v));
    if (want_v) begin
      e = exp_q.pop_front();
      check("cos", int'(cos_o), e.cos_exact);
      check("sin", int'(sin_o), e.sin_exact);
      check("cos_acc", int'(cos_o), e.cos_true, 16);
      check("sin_acc", int'(sin_o), e.sin_true, 16);
      check("half", int'(half_o), int'(e.half));
    end else if (exp_q.size() > 0 && exp_q[0].due < cycle) begin
      e = exp_q.pop_front();
      check("missed_due", cycle, e.due);
    end
  end

  logic [31:0] fp_dir [5] = '{32'h40000000, 32'hC0800000, 32'h7F800000,
                              32'h00800000, 32'h00000002};
  logic [31:0] hf_dir [5] = '{32'h3F800000, 32'hC0000000, 32'h7F800000,
                              32'h00400000, 32'h00000001};

  initial begin
    int wait_cnt;
    // Spec-quoted halving results cross-check the reference model itself
    for (int k = 0; k < 5; k++) begin
      logic [31:0] hv;
      hv = ref_half(fp_dir[k]);
      check("half_ref", int'(hv), int'(hf_dir[k]));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_cos", int'(valid_o), 0);
    rst = 1'b0;
    idle(2);

    send(0,        32'h40000000);
    send(411775,   32'hC0800000);
    send(-411775,  32'h7F800000);
    send(823550,   32'h00800000);
    send(-823550,  32'h00000002);
    idle(8);

    for (int k = 0; k < 20; k++)
      send(int'($urandom_range(0, 1572864)) - 786432, rand_fp());
    idle(8);

    // Reset with three samples in flight: they must never emerge
    send(100000, rand_fp());
    send(-200000, rand_fp());
    send(300000, rand_fp());
    @(posedge clk); #1;
    valid_i = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_valid", int'(valid_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(8);

    for (int k = 0; k < 10; k++)
      send(int'($urandom_range(0, 1572864)) - 786432, rand_fp());
    idle(1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("drain", exp_q.size(), 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
